cond_unit: RTL and testbench

Condition-check and flag-register stage for the ARM-like CPU. It takes the NZCV flags produced by the ALU, holds them in an architectural flag register, and evaluates each instruction's 4-bit condition field against the held flags. It gates the decoder's write and branch strobes through one registered pipeline stage, and keeps saturating executed/skipped instruction counters for debug.

---
 rtl/cond_if.sv | 32 +++
 rtl/cond_unit.sv | 70 +++++++
 tb/tb_cond_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/cond_if.sv
// Instruction/flag bus between the decoder/ALU and the condition unit.
interface cond_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             stall;
  logic [3:0]       Cond;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagW;
  logic             PCS;
  logic             RegW;
  logic             MemW;
  logic             NoWrite;
  logic             CondEx;
  logic [3:0]       Flags;
  logic             out_valid;
  logic             PCSrc;
  logic             RegWrite;
  logic             MemWrite;
  logic [CNT_W-1:0] exec_count;
  logic [CNT_W-1:0] skip_count;

  modport master (
    output in_valid, stall, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
    input  CondEx, Flags, out_valid, PCSrc, RegWrite, MemWrite, exec_count, skip_count
  );

  modport slave (
    input  in_valid, stall, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
    output CondEx, Flags, out_valid, PCSrc, RegWrite, MemWrite, exec_count, skip_count
  );
endinterface

// File: rtl/cond_unit.sv
// Condition check, architectural NZCV register, gated write/branch strobes
// and saturating executed/skipped counters.
module cond_unit #(
  parameter int CNT_W = 16
) (
  input logic   clk,
  input logic   reset,
  cond_if.slave bus
);
  logic flagN, flagZ, flagC, flagV;
  logic condEx;
  logic accept;

  assign flagN  = bus.Flags[3];
  assign flagZ  = bus.Flags[2];
  assign flagC  = bus.Flags[1];
  assign flagV  = bus.Flags[0];
  assign accept = bus.in_valid & ~bus.stall;

  // Evaluated against the held flags, so a flag-setting instruction never sees its own result
  always_comb begin
    condEx = 1'b0;
    case (bus.Cond)
      4'b0000: condEx = flagZ;
      4'b0001: condEx = ~flagZ;
      4'b0010: condEx = flagC;
      4'b0011: condEx = ~flagC;
      4'b0100: condEx = flagN;
      4'b0101: condEx = ~flagN;
      4'b0110: condEx = flagV;
      4'b0111: condEx = ~flagV;
      4'b1000: condEx = flagC & ~flagZ;
      4'b1001: condEx = ~flagC | flagZ;
      4'b1010: condEx = (flagN == flagV);
      4'b1011: condEx = (flagN != flagV);
      4'b1100: condEx = ~flagZ & (flagN == flagV);
      4'b1101: condEx = flagZ | (flagN != flagV);
      4'b1110: condEx = 1'b1;
      default: condEx = 1'b0;
    endcase
  end

  assign bus.CondEx = condEx;

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.Flags      <= 4'b0000;
      bus.out_valid  <= 1'b0;
      bus.PCSrc      <= 1'b0;
      bus.RegWrite   <= 1'b0;
      bus.MemWrite   <= 1'b0;
      bus.exec_count <= '0;
      bus.skip_count <= '0;
    end else if (!bus.stall) begin
      bus.out_valid <= accept;
      bus.PCSrc     <= accept & bus.PCS & condEx;
      bus.RegWrite  <= accept & bus.RegW & condEx & ~bus.NoWrite;
      bus.MemWrite  <= accept & bus.MemW & condEx;
      if (accept) begin
        if (condEx) begin
          if (bus.FlagW[1]) bus.Flags[3:2] <= bus.ALUFlags[3:2];
          if (bus.FlagW[0]) bus.Flags[1:0] <= bus.ALUFlags[1:0];
          if (bus.exec_count != {CNT_W{1'b1}}) bus.exec_count <= bus.exec_count + 1'b1;
        end else begin
          if (bus.skip_count != {CNT_W{1'b1}}) bus.skip_count <= bus.skip_count + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_cond_unit.sv
// Random plus directed checks of cond_unit against a flag/counter reference model;
// a 16-bit and a 4-bit counter instance see identical stimulus.
module tb_cond_unit;
  logic clk = 1'b0;
  logic reset;

  cond_if #(.CNT_W(16)) busMain ();
  cond_if #(.CNT_W(4))  busSmall ();

  cond_unit #(.CNT_W(16)) dutMain  (.clk(clk), .reset(reset), .bus(busMain));
  cond_unit #(.CNT_W(4))  dutSmall (.clk(clk), .reset(reset), .bus(busSmall));

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  logic [3:0] mFlags;
  logic       mValid, mPcsrc, mRegw, mMemw;
  int         mExec, mSkip;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Architectural condition meaning, written from the NZCV definitions
  function automatic logic modelCond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int sat(input int value, input int maxValue);
    return (value > maxValue) ? maxValue : value;
  endfunction

  task automatic driveBoth(input logic v, st, input logic [3:0] cond, alu, input logic [1:0] fw,
                           input logic pcs, regw, memw, nowr);
    busMain.in_valid  = v;    busSmall.in_valid  = v;
    busMain.stall     = st;   busSmall.stall     = st;
    busMain.Cond      = cond; busSmall.Cond      = cond;
    busMain.ALUFlags  = alu;  busSmall.ALUFlags  = alu;
    busMain.FlagW     = fw;   busSmall.FlagW     = fw;
    busMain.PCS       = pcs;  busSmall.PCS       = pcs;
    busMain.RegW      = regw; busSmall.RegW      = regw;
    busMain.MemW      = memw; busSmall.MemW      = memw;
    busMain.NoWrite   = nowr; busSmall.NoWrite   = nowr;
  endtask

  // One clock: drive, check CondEx, advance the model at the edge, check registered state
  task automatic applyStimulus(input logic rst, v, st, input logic [3:0] cond, alu,
                               input logic [1:0] fw, input logic pcs, regw, memw, nowr);
    logic ce;
    reset = rst;
    driveBoth(v, st, cond, alu, fw, pcs, regw, memw, nowr);
    #1;
    ce = modelCond(cond, mFlags);
    if (!rst) begin
      checkOutput("condex_main", {31'b0, busMain.CondEx}, {31'b0, ce});
      checkOutput("condex_small", {31'b0, busSmall.CondEx}, {31'b0, ce});
    end
    @(posedge clk);
    if (rst) begin
      mFlags = 4'b0; mValid = 0; mPcsrc = 0; mRegw = 0; mMemw = 0; mExec = 0; mSkip = 0;
    end else if (!st) begin
      mValid = v;
      mPcsrc = v && pcs && ce;
      mRegw  = v && regw && ce && !nowr;
      mMemw  = v && memw && ce;
      if (v) begin
        if (ce) begin
          if (fw[1]) mFlags[3:2] = alu[3:2];
          if (fw[0]) mFlags[1:0] = alu[1:0];
          mExec++;
        end else begin
          mSkip++;
        end
      end
    end
    @(negedge clk);
    checkOutput("flags", {28'b0, busMain.Flags}, {28'b0, mFlags});
    checkOutput("flags_small", {28'b0, busSmall.Flags}, {28'b0, mFlags});
    checkOutput("out_valid", {31'b0, busMain.out_valid}, {31'b0, mValid});
    checkOutput("pcsrc", {31'b0, busMain.PCSrc}, {31'b0, mPcsrc});
    checkOutput("regwrite", {31'b0, busMain.RegWrite}, {31'b0, mRegw});
    checkOutput("memwrite", {31'b0, busMain.MemWrite}, {31'b0, mMemw});
    checkOutput("exec16", {16'b0, busMain.exec_count}, sat(mExec, 65535));
    checkOutput("skip16", {16'b0, busMain.skip_count}, sat(mSkip, 65535));
    checkOutput("exec4", {28'b0, busSmall.exec_count}, sat(mExec, 15));
    checkOutput("skip4", {28'b0, busSmall.skip_count}, sat(mSkip, 15));
  endtask

  task automatic probeCond(input string tag, input logic [3:0] cond, input logic expected);
    driveBoth(1'b0, 1'b0, cond, 4'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput(tag, {31'b0, busMain.CondEx}, {31'b0, expected});
  endtask

  initial begin
    int execBefore;
    mFlags = 4'b0; mValid = 0; mPcsrc = 0; mRegw = 0; mMemw = 0; mExec = 0; mSkip = 0;

    // Reset held two cycles with a live AL register write present
    applyStimulus(1, 1, 0, 4'b1110, 4'b1111, 2'b11, 0, 1, 0, 0);
    applyStimulus(1, 1, 0, 4'b1110, 4'b1111, 2'b11, 0, 1, 0, 0);
    checkOutput("rst_flags", {28'b0, busMain.Flags}, 32'h0);
    checkOutput("rst_regwrite", {31'b0, busMain.RegWrite}, 32'h0);
    probeCond("rst_eq", 4'b0000, 1'b0);
    probeCond("rst_ne", 4'b0001, 1'b1);
    probeCond("rst_al", 4'b1110, 1'b1);

    // SUB overflow, then VS / VC
    applyStimulus(0, 1, 0, 4'b1110, 4'b0011, 2'b11, 0, 0, 0, 1);
    checkOutput("sub_flags", {28'b0, busMain.Flags}, 32'h3);
    applyStimulus(0, 1, 0, 4'b0110, 4'b0000, 2'b00, 0, 1, 0, 0);
    checkOutput("vs_regwrite", {31'b0, busMain.RegWrite}, 32'h1);
    applyStimulus(0, 1, 0, 4'b0111, 4'b0000, 2'b00, 0, 1, 0, 0);
    checkOutput("vc_regwrite", {31'b0, busMain.RegWrite}, 32'h0);
    checkOutput("vc_skip", {16'b0, busMain.skip_count}, 32'h1);

    // ADD overflow, then GE / GT / LT
    applyStimulus(0, 1, 0, 4'b1110, 4'b1001, 2'b11, 0, 0, 0, 1);
    checkOutput("add_flags", {28'b0, busMain.Flags}, 32'h9);
    probeCond("add_ge", 4'b1010, 1'b1);
    probeCond("add_gt", 4'b1100, 1'b1);
    probeCond("add_lt", 4'b1011, 1'b0);

    // Partial C,V write, then a failing EQ must not touch the flags
    applyStimulus(0, 1, 0, 4'b1110, 4'b0110, 2'b01, 0, 0, 0, 1);
    checkOutput("partial_flags", {28'b0, busMain.Flags}, 32'hA);
    applyStimulus(0, 1, 0, 4'b0000, 4'b1111, 2'b11, 1, 1, 1, 0);
    checkOutput("eq_gated_flags", {28'b0, busMain.Flags}, 32'hA);
    checkOutput("eq_gated_pcsrc", {31'b0, busMain.PCSrc}, 32'h0);

    // Stall three cycles with a flag-writing instruction waiting
    execBefore = int'(busMain.exec_count);
    repeat (3) applyStimulus(0, 1, 1, 4'b1110, 4'b0101, 2'b11, 1, 1, 1, 0);
    checkOutput("stall_flags", {28'b0, busMain.Flags}, 32'hA);
    applyStimulus(0, 1, 0, 4'b1110, 4'b0101, 2'b11, 1, 1, 1, 0);
    applyStimulus(0, 0, 0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0);
    checkOutput("stall_once", {16'b0, busMain.exec_count}, execBefore + 1);
    checkOutput("stall_release_flags", {28'b0, busMain.Flags}, 32'h5);

    // Saturation of the 4-bit instance
    applyStimulus(1, 0, 0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0);
    repeat (17) applyStimulus(0, 1, 0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0);
    checkOutput("sat_exec4", {28'b0, busSmall.exec_count}, 32'hF);
    checkOutput("sat_skip4", {28'b0, busSmall.skip_count}, 32'h0);
    checkOutput("sat_exec16", {16'b0, busMain.exec_count}, 32'd17);
    repeat (3) applyStimulus(0, 1, 0, 4'b1111, 4'b0000, 2'b11, 1, 1, 1, 0);
    checkOutput("nv_exec4", {28'b0, busSmall.exec_count}, 32'hF);
    checkOutput("nv_skip4", {28'b0, busSmall.skip_count}, 32'h3);

    // Randomized traffic, including occasional mid-stream reset
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 4) == 0), 4'($urandom), 4'($urandom), 2'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
